// File: rtl/video_pattern_checker.sv
// video_pattern_checker: sink-side checker for the tiled four-colour test
// pattern. Pulls pixels via VideoReady, compares each accepted pixel against a
// regenerated expected colour, and counts mismatches and completed frames.
// Optional first-error capture is enabled by defining
// VIDEO_PATTERN_CHECKER_CAPTURE_EN; otherwise the capture outputs read 0.
module video_pattern_checker #(
  parameter int H_PIXELS = 800,
  parameter int V_LINES  = 600,
  parameter int TILE_W   = 80,
  parameter int TILE_H   = 50
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Enable,
  input  logic        Stall,
  input  logic        ErrorClear,
  input  logic [23:0] video,
  output logic        VideoReady,
  output logic        Error,
  output logic [15:0] ErrorCount,
  output logic        FrameDone,
  output logic [15:0] FrameCount,
  output logic        FirstErrValid,
  output logic [9:0]  FirstErrX,
  output logic [9:0]  FirstErrY,
  output logic [23:0] FirstErrPixel
);

  localparam int TILES_PER_BAND = (H_PIXELS / TILE_W) * TILE_H;
  localparam int PIX_W          = $clog2(TILE_W + 1);
  localparam int TILE_CNT_W     = $clog2(TILES_PER_BAND + 1);

  localparam logic [23:0] COLOUR_T = {8'd26,  8'd188, 8'd156};
  localparam logic [23:0] COLOUR_C = {8'd230, 8'd126, 8'd34};
  localparam logic [23:0] COLOUR_S = {8'd241, 8'd196, 8'd15};
  localparam logic [23:0] COLOUR_E = {8'd46,  8'd204, 8'd113};

  // T/C alternate in A bands, S/E in B bands.
  typedef enum logic [1:0] {ST_T, ST_C, ST_S, ST_E} colour_state_t;

  colour_state_t          state;
  logic [PIX_W-1:0]       pix_in_tile;
  logic [TILE_CNT_W-1:0]  tile_cnt;
  logic [9:0]             x;
  logic [9:0]             y;
  logic [23:0]            expected;
  logic                   accept;
  logic                   mismatch;
  logic                   last_pix;
  logic                   last_tile;
  logic                   last_x;
  logic                   last_y;
  logic                   frame_end;

  assign accept    = VideoReady;
  assign last_pix  = (pix_in_tile == PIX_W'(TILE_W - 1));
  assign last_tile = (tile_cnt == TILE_CNT_W'(TILES_PER_BAND - 1));
  assign last_x    = (x == 10'(H_PIXELS - 1));
  assign last_y    = (y == 10'(V_LINES - 1));
  assign frame_end = last_x && last_y;
  assign mismatch  = accept && (video != expected);

  // Expected colour is a direct decode of the current state so each pixel is
  // checked on the edge that accepts it.
  always_comb begin
    // NOTE: assigning a default before the case keeps this block latch-free.
    expected = COLOUR_T;
    case (state)
      ST_T: expected = COLOUR_T;
      ST_C: expected = COLOUR_C;
      ST_S: expected = COLOUR_S;
      ST_E: expected = COLOUR_E;
      default: expected = COLOUR_T;
    endcase
  end

  // Registered pull strobe: request a pixel whenever enabled and not stalled.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // pre-edge values regardless of block ordering.
      VideoReady <= 1'b0;
    end else begin
      VideoReady <= Enable & ~Stall;
    end
  end

  // Position tracking, tile/band colour FSM and frame accounting.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_T;
      pix_in_tile <= '0;
      tile_cnt    <= '0;
      x           <= '0;
      y           <= '0;
      FrameDone   <= 1'b0;
      FrameCount  <= '0;
    end else begin
      FrameDone <= 1'b0;
      if (accept) begin
        x <= last_x ? 10'd0 : x + 10'd1;
        if (last_x) begin
          y <= last_y ? 10'd0 : y + 10'd1;
        end

        if (frame_end) begin
          // End of frame realigns everything to the top-left T tile.
          state       <= ST_T;
          pix_in_tile <= '0;
          tile_cnt    <= '0;
          FrameDone   <= 1'b1;
          FrameCount  <= FrameCount + 16'd1;
        end else begin
          pix_in_tile <= last_pix ? '0 : pix_in_tile + 1'b1;
          if (last_pix) begin
            tile_cnt <= last_tile ? '0 : tile_cnt + 1'b1;
            if (last_tile) begin
              // Band change: A bands hand over to S, B bands to T.
              state <= (state == ST_T || state == ST_C) ? ST_S : ST_T;
            end else begin
              case (state)
                ST_T: state <= ST_C;
                ST_C: state <= ST_T;
                ST_S: state <= ST_E;
                ST_E: state <= ST_S;
                default: state <= ST_T;
              endcase
            end
          end
        end
      end
    end
  end

  // Mismatch pulse and saturating counter; a clear on a mismatching beat
  // leaves the count at one.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Error      <= 1'b0;
      ErrorCount <= '0;
    end else begin
      Error <= mismatch;
      if (ErrorClear) begin
        ErrorCount <= mismatch ? 16'd1 : 16'd0;
      end else if (mismatch && (ErrorCount != 16'hFFFF)) begin
        ErrorCount <= ErrorCount + 16'd1;
      end
    end
  end

`ifdef VIDEO_PATTERN_CHECKER_CAPTURE_EN
  logic take_capture;

  assign take_capture = mismatch && (ErrorClear || !FirstErrValid);

  // First-error capture; a simultaneous clear re-arms it for the new error.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      FirstErrValid <= 1'b0;
      FirstErrX     <= '0;
      FirstErrY     <= '0;
      FirstErrPixel <= '0;
    end else if (take_capture) begin
      FirstErrValid <= 1'b1;
      FirstErrX     <= x;
      FirstErrY     <= y;
      FirstErrPixel <= video;
    end else if (ErrorClear) begin
      FirstErrValid <= 1'b0;
      FirstErrX     <= '0;
      FirstErrY     <= '0;
      FirstErrPixel <= '0;
    end
  end
`else
  assign FirstErrValid = 1'b0;
  assign FirstErrX     = '0;
  assign FirstErrY     = '0;
  assign FirstErrPixel = '0;
`endif

endmodule

// File: tb/tb_video_pattern_checker.sv
// Directed bench for video_pattern_checker on a reduced 16x8 frame with 4x2
// tiles (bands of 2 lines, frame of 128 pixels). The pattern source is an
// independent position-based model advanced on every accepted beat.
module tb_video_pattern_checker;

  localparam int H     = 16;
  localparam int V     = 8;
  localparam int TW    = 4;
  localparam int TH    = 2;
  localparam int FRAME = H * V;

`ifdef VIDEO_PATTERN_CHECKER_CAPTURE_EN
  localparam bit CAP_ON = 1'b1;
`else
  localparam bit CAP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        stall = 1'b0;
  logic        error_clear = 1'b0;
  logic [23:0] video;
  logic        video_ready;
  logic        error;
  logic [15:0] error_count;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        first_err_valid;
  logic [9:0]  first_err_x;
  logic [9:0]  first_err_y;
  logic [23:0] first_err_pixel;

  int total = 0;
  int bad = 0;
  int beat = 0;
  int bad_beat = -1;
  bit bad_all = 1'b0;
  bit stall_rand = 1'b0;
  int fd_count = 0;
  int fd_beat [8];
  int err_pulses = 0;
  int err_last_beat = -1;

  video_pattern_checker #(
    .H_PIXELS(H), .V_LINES(V), .TILE_W(TW), .TILE_H(TH)
  ) dut (
    .Clock(clk),
    .Reset_n(rst_n),
    .Enable(enable),
    .Stall(stall),
    .ErrorClear(error_clear),
    .video(video),
    .VideoReady(video_ready),
    .Error(error),
    .ErrorCount(error_count),
    .FrameDone(frame_done),
    .FrameCount(frame_count),
    .FirstErrValid(first_err_valid),
    .FirstErrX(first_err_x),
    .FirstErrY(first_err_y),
    .FirstErrPixel(first_err_pixel)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] model_pixel(input int b);
    int p, xx, yy, band, par;
    p    = b % FRAME;
    yy   = p / H;
    xx   = p % H;
    band = yy / TH;
    par  = ((yy % TH) * (H / TW) + xx / TW) % 2;
    if (band % 2 == 0) return (par != 0) ? 24'hE67E22 : 24'h1ABC9C;
    else               return (par != 0) ? 24'h2ECC71 : 24'hF1C40F;
  endfunction

  // Pattern source: advances on every accepted beat, shares the reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat <= 0;
    else if (video_ready) beat <= beat + 1;
  end

  assign video = bad_all ? 24'hFFFFFF :
                 (beat == bad_beat) ? 24'h000000 : model_pixel(beat);

  // Output monitor, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (frame_done) begin
      fd_count = fd_count + 1;
      if (fd_count < 8) fd_beat[fd_count] = beat;
    end
    if (error) begin
      err_pulses    = err_pulses + 1;
      err_last_beat = beat;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (fd_count < n && c < budget) begin
      @(negedge clk);
      c++;
      if (stall_rand) stall = 1'($urandom_range(0, 1));
    end
    check("frame_wait", 32'(fd_count >= n), 32'd1);
  endtask

  task automatic wait_beat(input int n, input int budget);
    int c = 0;
    while (beat < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("beat_wait", 32'(beat >= n), 32'd1);
  endtask

  initial begin
    int e0, b0, bc;

    // Reset state.
    @(negedge clk);
    check("rst_ready", 32'(video_ready), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_errcnt", 32'(error_count), 32'd0);
    check("rst_fdone", 32'(frame_done), 32'd0);
    check("rst_fcnt", 32'(frame_count), 32'd0);
    check("rst_capv", 32'(first_err_valid), 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;

    // Enable dropped mid-line: ready falls one cycle later, source holds.
    e0 = err_pulses;
    wait_beat(10, 100);
    enable = 1'b0;
    @(negedge clk);
    check("en_drop_ready", 32'(video_ready), 32'd0);
    b0 = beat;
    repeat (10) @(negedge clk);
    check("en_drop_hold", 32'(beat), 32'(b0));
    enable = 1'b1;

    // Two clean frames.
    wait_frames(2, 1000);
    check("clean_errcnt", 32'(error_count), 32'd0);
    check("clean_fcnt", 32'(frame_count), 32'd2);
    check("clean_fd1_beat", 32'(fd_beat[1]), 32'(FRAME));
    check("clean_fd2_beat", 32'(fd_beat[2]), 32'(2 * FRAME));
    check("clean_err_pulses", 32'(err_pulses - e0), 32'd0);

    // Random backpressure over a full frame.
    stall_rand = 1'b1;
    wait_frames(3, 2000);
    stall_rand = 1'b0;
    stall      = 1'b0;
    check("stall_errcnt", 32'(error_count), 32'd0);
    check("stall_fcnt", 32'(frame_count), 32'd3);
    check("stall_err_pulses", 32'(err_pulses - e0), 32'd0);

    // Single corrupted pixel at x=5, y=2 of frame 4.
    bad_beat = 3 * FRAME + 37;
    wait_frames(4, 1000);
    check("one_err_pulses", 32'(err_pulses - e0), 32'd1);
    check("one_err_beat", 32'(err_last_beat), 32'(3 * FRAME + 38));
    check("one_errcnt", 32'(error_count), 32'd1);
    check("one_capv", 32'(first_err_valid), 32'(CAP_ON));
    check("one_capx", 32'(first_err_x), CAP_ON ? 32'd5 : 32'd0);
    check("one_capy", 32'(first_err_y), CAP_ON ? 32'd2 : 32'd0);
    check("one_cappix", 32'(first_err_pixel), 32'd0);

    // Second error (x=6, y=4) must not overwrite the capture.
    bad_beat = 4 * FRAME + 70;
    wait_frames(5, 1000);
    bad_beat = -1;
    check("two_errcnt", 32'(error_count), 32'd2);
    check("two_err_beat", 32'(err_last_beat), 32'(4 * FRAME + 71));
    check("two_capx", 32'(first_err_x), CAP_ON ? 32'd5 : 32'd0);
    check("two_capy", 32'(first_err_y), CAP_ON ? 32'd2 : 32'd0);
    check("two_fcnt", 32'(frame_count), 32'd5);

    // Clear with no traffic.
    enable = 1'b0;
    repeat (3) @(negedge clk);
    error_clear = 1'b1;
    @(negedge clk);
    error_clear = 1'b0;
    check("clr_errcnt", 32'(error_count), 32'd0);
    check("clr_capv", 32'(first_err_valid), 32'd0);

    // Saturation with a constant white source.
    bad_all = 1'b1;
    enable  = 1'b1;
    repeat (65540) @(negedge clk);
    check("sat_errcnt", 32'(error_count), 32'hFFFF);
    repeat (10) @(negedge clk);
    check("sat_hold", 32'(error_count), 32'hFFFF);
    check("sat_error_pulse", 32'(error), 32'd1);

    // Clear on a mismatching beat: count restarts at one, capture re-arms.
    bc = beat;
    error_clear = 1'b1;
    @(negedge clk);
    error_clear = 1'b0;
    check("clrmis_errcnt", 32'(error_count), 32'd1);
    check("clrmis_capv", 32'(first_err_valid), 32'(CAP_ON));
    check("clrmis_capx", 32'(first_err_x), CAP_ON ? 32'((bc % FRAME) % H) : 32'd0);
    check("clrmis_capy", 32'(first_err_y), CAP_ON ? 32'((bc % FRAME) / H) : 32'd0);
    check("clrmis_cappix", 32'(first_err_pixel), CAP_ON ? 32'hFFFFFF : 32'd0);
    bad_all = 1'b0;

    // Asynchronous reset between edges, mid-frame.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(video_ready), 32'd0);
    check("arst_errcnt", 32'(error_count), 32'd0);
    check("arst_fcnt", 32'(frame_count), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    e0 = err_pulses;
    wait_beat(40, 200);
    check("post_rst_errcnt", 32'(error_count), 32'd0);
    check("post_rst_err_pulses", 32'(err_pulses - e0), 32'd0);
    check("post_rst_fcnt", 32'(frame_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_pattern_checker.md
# video_pattern_checker

Sink-side checker for the tiled four-colour test pattern stream. It pulls pixels from the pattern source by driving `VideoReady` and compares each accepted 24-bit pixel against an internally regenerated expected colour. It counts mismatches and frames. It sits between the pattern generator and the status/debug register bank, so that any consumer path can be validated in hardware without a display.

## Interface
Parameters:
- `H_PIXELS`, 800: pixels per line.
- `V_LINES`, 600: lines per frame.
- `TILE_W`, 80: pixels per tile, horizontal.
- `TILE_H`, 50: lines per colour band.

Ports:
- `Clock`, in, 1: single clock; all logic on its rising edge.
- `Reset_n`, in, 1: asynchronous, active-low reset.
- `Enable`, in, 1: request pixels and check them.
- `Stall`, in, 1: backpressure; while high, no pixel is requested.
- `ErrorClear`, in, 1: synchronous pulse; clears `ErrorCount` and first-error capture.
- `video`, in, 24: pixel from the source, `{R,G,B}`; valid whenever `VideoReady` is high.
- `VideoReady`, out, 1: accept strobe; the source advances on every cycle in which it is high.
- `Error`, out, 1: one-cycle pulse per mismatching pixel.
- `ErrorCount`, out, 16: mismatch count; saturating.
- `FrameDone`, out, 1: one-cycle pulse after the last pixel of a frame is checked.
- `FrameCount`, out, 16: completed frames; wraps.
- `FirstErrValid`, out, 1: first-error capture valid.
- `FirstErrX`, out, 10: pixel column of the first mismatch.
- `FirstErrY`, out, 10: line of the first mismatch.
- `FirstErrPixel`, out, 24: received value at the first mismatch.

## Operation
- Colours:
  - T = {26,188,156}
  - C = {230,126,34}
  - S = {241,196,15}
  - E = {46,204,113}
- Expected-colour FSM has states `T`, `C`, `S`, `E`. Reset state is `T`.
- Tile advance:
  - Each accepted pixel increments `pix_in_tile` (0..TILE_W-1).
  - On wrap, the tile toggles: T↔C in A bands, S↔E in B bands.
- Band advance:
  - A running tile counter, 0..(H_PIXELS/TILE_W)*TILE_H-1, counts tiles within the band.
  - On its wrap, the FSM goes from any A state to `S`, and from any B state to `T`.
- Position:
  - `x` runs 0..H_PIXELS-1 and wraps into `y`.
  - `y` runs 0..V_LINES-1.
  - The pixel at x=H_PIXELS-1, y=V_LINES-1 ends the frame: `x` and `y` go to 0 and the FSM returns to `T`.
- Accept rule: a pixel is accepted and checked only on a cycle where `VideoReady`=1. Position and FSM state hold otherwise.
- Mismatch, meaning `video` ≠ expected on an accepted cycle:
  - `Error` pulses.
  - `ErrorCount` increments and saturates at 16'hFFFF.
  - If `FirstErrValid`=0, capture `x`, `y` and `video`, and set `FirstErrValid`.
- `ErrorClear` together with a mismatch on the same cycle: the clear applies first, so `ErrorCount`=1 and the capture holds the new error.
- Dropping `Enable` mid-frame holds all position state. Checking resumes with the next pixel when `Enable` returns.
- Reset values:
  - all outputs 0
  - position 0
  - FSM `T`
  - internal tile counters 0
- `Reset_n` assertion mid-frame drops `VideoReady` immediately. The source must be reset with the same `Reset_n` to stay aligned.

## Timing
- `VideoReady` is registered: `VideoReady` ← `Enable & ~Stall`, one cycle after the inputs.
- `video` is sampled on the same edge on which `VideoReady`=1 is seen. The comparison uses combinational expected-colour state, so each pixel is checked on its acceptance edge.
- Output latencies after the acceptance edge, all registered:
  - `Error`: 1 cycle.
  - `ErrorCount`: 1 cycle.
  - First-error capture: 1 cycle.
  - `FrameDone`: 1 cycle.
  - `FrameCount`: updates together with `FrameDone`.
- Throughput is one pixel per clock with `Stall`=0.

## Configuration
- `VIDEO_PATTERN_CHECKER_CAPTURE_EN` defined: first-error capture is implemented as described above.
- Macro undefined:
  - `FirstErrValid`, `FirstErrX`, `FirstErrY` and `FirstErrPixel` are tied to 0.
  - No capture registers exist.
  - All other behaviour is identical.

## Test plan
- Generator connected; `Enable`=1, `Stall`=0; run 960000 clocks → `ErrorCount`=0; `FrameDone` pulses after beats 480000 and 960000; `FrameCount`=2.
- Override `video`=24'h000000 on accepted beat 80 only (x=80, y=0) → one `Error` pulse; `ErrorCount`=1; capture X=80, Y=0, pixel 0 (macro defined).
- Pseudo-random 50% `Stall`, one full frame → `ErrorCount`=0; beat 40000 checked against S={241,196,15}; beat 40080 checked against E.
- Feed constant 24'hFFFFFF for 70000 accepted beats → `ErrorCount`=16'hFFFF and holds; `ErrorClear` on a mismatching beat → `ErrorCount`=1.
- Toggle `Enable` low for 100 cycles mid-line → `VideoReady`=0 one cycle after `Enable` falls; no errors after resume; frame completes at beat 480000.
- Assert `Reset_n` low mid-frame, asynchronously between edges → `VideoReady`, `ErrorCount` and `FrameCount` read 0 immediately; after release, first checked pixel expects T.
